// File: rtl/sd_card_dat_responder.sv
// sd_card_dat_responder: card end of one SD DAT line for write blocks; receives data+CRC16,
// then answers with the CRC status token and busy, streaming received data out as 32-bit words.
module sd_card_dat_responder #(
    parameter int BLOCK_BITS  = 512,
    parameter int NCRC        = 2,
    parameter int BUSY_CYCLES = 8
) (
    input  logic        sd_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        force_crc_err,
    input  logic        dat_in,
    output logic        dat_out,
    output logic        dat_oe,
    output logic [31:0] rx_word,
    output logic        rx_word_valid,
    output logic        block_done,
    output logic        crc_ok,
    output logic [15:0] block_count
);
    localparam int BW = $clog2(BLOCK_BITS);

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_CRC, S_END, S_WAIT, S_STATUS, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   crc_q, crc_d, crc_next;
    logic [15:0]   rx_crc_q, rx_crc_d;
    logic [31:0]   sh_q, sh_d;
    logic [31:0]   rx_word_q, rx_word_d;
    logic          rx_word_valid_q, rx_word_valid_d;
    logic          ok_q, ok_d;
    logic          block_done_q, block_done_d;
    logic          crc_ok_q, crc_ok_d;
    logic [15:0]   block_count_q, block_count_d;
    logic          dat_out_q, dat_out_d;
    logic          dat_oe_q, dat_oe_d;
    logic [4:0]    tok;

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        cnt_d           = cnt_q;
        crc_d           = crc_q;
        rx_crc_d        = rx_crc_q;
        sh_d            = sh_q;
        rx_word_d       = rx_word_q;
        rx_word_valid_d = 1'b0;
        ok_d            = ok_q;
        block_done_d    = 1'b0;
        crc_ok_d        = crc_ok_q;
        block_count_d   = block_count_q;
        crc_next        = {crc_q[14:0], 1'b0} ^ ((dat_in ^ crc_q[15]) ? 16'h1021 : 16'h0000);
        case (state_q)
            S_IDLE: begin
                if (enable && !dat_in) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                    crc_d     = '0;
                end
            end
            S_DATA: begin
                crc_d     = crc_next;
                sh_d      = {sh_q[30:0], dat_in};
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q[4:0] == 5'd31) begin
                    rx_word_d       = sh_d;
                    rx_word_valid_d = 1'b1;
                end
                if (bit_cnt_q == BW'(BLOCK_BITS - 1)) begin
                    state_d = S_CRC;
                    cnt_d   = '0;
                end
            end
            S_CRC: begin
                rx_crc_d = {rx_crc_q[14:0], dat_in};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == 16'd15) begin
                    state_d = S_END;
                    cnt_d   = '0;
                end
            end
            S_END: begin
                ok_d    = dat_in && (rx_crc_q == crc_q) && !force_crc_err;
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 16'(NCRC - 1)) begin
                    state_d       = S_STATUS;
                    cnt_d         = '0;
                    block_done_d  = 1'b1;
                    crc_ok_d      = ok_q;
                    block_count_d = block_count_q + 1'b1;
                end
            end
            S_STATUS: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 16'd4) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == 16'(BUSY_CYCLES)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // token bits indexed by cycle: accepted 0,0,1,0,1; CRC error 0,1,0,1,1
        tok       = ok_q ? 5'b10100 : 5'b11010;
        dat_oe_d  = (state_d == S_STATUS) || (state_d == S_BUSY);
        dat_out_d = (state_d == S_STATUS) ? tok[cnt_d[2:0]] :
                    (state_d == S_BUSY) ? (cnt_d == 16'(BUSY_CYCLES)) : 1'b1;
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            bit_cnt_q       <= '0;
            cnt_q           <= '0;
            crc_q           <= '0;
            rx_crc_q        <= '0;
            sh_q            <= '0;
            rx_word_q       <= '0;
            rx_word_valid_q <= 1'b0;
            ok_q            <= 1'b0;
            block_done_q    <= 1'b0;
            crc_ok_q        <= 1'b0;
            block_count_q   <= '0;
            dat_out_q       <= 1'b1;
            dat_oe_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            cnt_q           <= cnt_d;
            crc_q           <= crc_d;
            rx_crc_q        <= rx_crc_d;
            sh_q            <= sh_d;
            rx_word_q       <= rx_word_d;
            rx_word_valid_q <= rx_word_valid_d;
            ok_q            <= ok_d;
            block_done_q    <= block_done_d;
            crc_ok_q        <= crc_ok_d;
            block_count_q   <= block_count_d;
            dat_out_q       <= dat_out_d;
            dat_oe_q        <= dat_oe_d;
        end
    end

    assign dat_out       = dat_out_q;
    assign dat_oe        = dat_oe_q;
    assign rx_word       = rx_word_q;
    assign rx_word_valid = rx_word_valid_q;
    assign block_done    = block_done_q;
    assign crc_ok        = crc_ok_q;
    assign block_count   = block_count_q;
endmodule

// File: tb/tb_sd_card_dat_responder.sv
// tb_sd_card_dat_responder: host-side driver for the DAT responder; predicts words, token,
// busy and counters from a block-level reference model.
module tb_sd_card_dat_responder;
    logic        sd_clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        force_crc_err = 1'b0;
    logic        host = 1'b1;
    logic        dat_in;
    logic        dat_out, dat_oe, rx_word_valid, block_done, crc_ok;
    logic [31:0] rx_word;
    logic [15:0] block_count;

    int          vectors = 0;
    int          errors = 0;
    logic [15:0] exp_count = 16'd0;
    logic [31:0] blk [16];

    assign dat_in = dat_oe ? dat_out : host;

    sd_card_dat_responder dut (
        .sd_clock(sd_clock), .reset(reset), .enable(enable), .force_crc_err(force_crc_err),
        .dat_in(dat_in), .dat_out(dat_out), .dat_oe(dat_oe), .rx_word(rx_word),
        .rx_word_valid(rx_word_valid), .block_done(block_done), .crc_ok(crc_ok),
        .block_count(block_count)
    );

    always #5 sd_clock = ~sd_clock;

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    function automatic logic [15:0] crc16_of_blk();
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int w = 0; w < 16; w++)
            for (int b = 31; b >= 0; b--) begin
                fb = blk[w][b] ^ c[15];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    task automatic fill_random();
        for (int w = 0; w < 16; w++) blk[w] = $urandom;
    endtask

    // Sends one block (optionally corrupting a data bit after the CRC or dropping the end bit)
    // and checks the words, the status/busy waveform and the counters.
    task automatic send_block(input bit flip, input bit bad_end, input string name);
        logic [31:0] tx [16];
        logic [15:0] c;
        logic [4:0]  tok;
        logic        ok, eoe, eout, ev;
        int          fpos;
        c    = crc16_of_blk();
        fpos = int'($urandom_range(511, 0));
        for (int w = 0; w < 16; w++) tx[w] = blk[w];
        if (flip) tx[fpos / 32][31 - fpos % 32] = ~tx[fpos / 32][31 - fpos % 32];
        ok = !flip && !bad_end && !force_crc_err;
        host = 1'b0;
        tick();
        for (int i = 0; i < 512; i++) begin
            host = tx[i / 32][31 - i % 32];
            tick();
            ev = (i % 32 == 31);
            vectors++;
            if (rx_word_valid !== ev) begin
                errors++;
                $display("FAIL %s rx_word_valid bit %0d: got %b want %b", name, i, rx_word_valid, ev);
            end
            if (ev) begin
                vectors++;
                if (rx_word !== tx[i / 32]) begin
                    errors++;
                    $display("FAIL %s rx_word[%0d]: got %h want %h", name, i / 32, rx_word, tx[i / 32]);
                end
            end
        end
        for (int j = 15; j >= 0; j--) begin
            host = c[j];
            tick();
        end
        host = bad_end ? 1'b0 : 1'b1;
        tick();
        host = 1'b1;
        tok = ok ? 5'b10100 : 5'b11010;
        exp_count++;
        for (int k = 0; k < 17; k++) begin
            eoe  = (k >= 2 && k < 16);
            eout = (k < 7) ? tok[k - 2] : (k == 15);
            vectors++;
            if (dat_oe !== eoe || (eoe && dat_out !== eout)) begin
                errors++;
                $display("FAIL %s response[%0d]: got oe=%b out=%b want oe=%b out=%b",
                         name, k, dat_oe, dat_out, eoe, eout);
            end
            vectors++;
            if (block_done !== (k == 2)) begin
                errors++;
                $display("FAIL %s block_done[%0d]: got %b want %b", name, k, block_done, k == 2);
            end
            if (k == 2 || k == 16) begin
                vectors += 2;
                if (crc_ok !== ok) begin
                    errors++;
                    $display("FAIL %s crc_ok[%0d]: got %b want %b", name, k, crc_ok, ok);
                end
                if (block_count !== exp_count) begin
                    errors++;
                    $display("FAIL %s block_count[%0d]: got %0d want %0d", name, k, block_count, exp_count);
                end
            end
            if (k < 16) tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({dat_out, dat_oe, rx_word, rx_word_valid, block_done, crc_ok, block_count} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state: got out=%b oe=%b word=%h v=%b bd=%b ok=%b cnt=%0d want 1 0 0 0 0 0 0",
                     dat_out, dat_oe, rx_word, rx_word_valid, block_done, crc_ok, block_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_good();
        for (int w = 0; w < 16; w++) blk[w] = 32'h0000_1EF4;
        send_block(1'b0, 1'b0, "good");
    endtask

    task automatic test_flip();
        send_block(1'b1, 1'b0, "flip");
    endtask

    task automatic test_force();
        force_crc_err = 1'b1;
        fill_random();
        send_block(1'b0, 1'b0, "force");
        force_crc_err = 1'b0;
    endtask

    task automatic test_missing_end();
        fill_random();
        send_block(1'b0, 1'b1, "no_end");
    endtask

    task automatic test_reset_mid();
        fill_random();
        host = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            host = $urandom_range(1, 0);
            tick();
        end
        #1 reset = 1'b0;
        tick();
        vectors++;
        if (dat_oe !== 1'b0 || block_count !== 16'd0 || rx_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: got oe=%b cnt=%0d word=%h want oe=0 cnt=0 word=0", dat_oe, block_count, rx_word);
        end
        exp_count = 16'd0;
        host = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        send_block(1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] start;
        start = block_count;
        for (int b = 0; b < 4; b++) begin
            fill_random();
            send_block(1'b0, 1'b0, "b2b");
        end
        vectors++;
        if (block_count !== start + 16'd4) begin
            errors++;
            $display("FAIL b2b_count: got %0d want %0d", block_count, start + 16'd4);
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 3; b++) begin
            fill_random();
            force_crc_err = 1'($urandom_range(1, 0));
            send_block(1'($urandom_range(1, 0)), 1'b0, "random");
        end
        force_crc_err = 1'b0;
    endtask

    task automatic test_enable_off();
        enable = 1'b0;
        host = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (dat_oe !== 1'b0 || rx_word_valid !== 1'b0 || block_done !== 1'b0) begin
                errors++;
                $display("FAIL enable_off[%0d]: got oe=%b v=%b bd=%b want 0 0 0", i, dat_oe, rx_word_valid, block_done);
            end
        end
        host = 1'b1;
        tick();
        enable = 1'b1;
        fill_random();
        send_block(1'b0, 1'b0, "after_enable");
    endtask

    initial begin
        test_reset();
        test_good();
        test_flip();
        test_force();
        test_missing_end();
        test_reset_mid();
        test_back_to_back();
        test_random();
        test_enable_off();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
